fround_pipe: RTL and testbench

FROUND_PIPE -- requirements
Module: fround_pipe

---
 rtl/fround_pipe.sv | 150 +++++++++++++++
 tb/tb_fround_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fround_pipe.sv
// Pipelined binary32 round-to-integral unit: floor/ceil/trunc/nearest-even,
// returning either a binary32 integral value or a signed int32.
module fround_pipe #(
  parameter int STAGES  = 2,
  parameter bit SAT_INT = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  logic        to_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic [15:0] ovf_cnt
);

  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] man;
  logic [23:0] sig;

  assign sgn  = x[31];
  assign expo = x[30:23];
  assign man  = x[22:0];
  assign sig  = {1'b1, man};

  logic [7:0]  rsh;
  logic [7:0]  lsh;
  logic [47:0] win;
  logic [23:0] ip;
  logic [23:0] rmag;
  logic        half;
  logic        rest;
  logic        inc;
  logic [4:0]  msb;
  logic [22:0] norm;
  logic [31:0] mag32;
  logic [31:0] wrap;
  logic        is_nan;
  logic        in_range;
  logic [31:0] res_y;
  logic        res_ovf;

  // The whole rounding datapath is evaluated before the first stage register;
  // the remaining stages only carry the finished result.
  always_comb begin
    rsh  = 8'd150 - expo;
    lsh  = expo - 8'd150;
    win  = {sig, 24'd0} >> rsh;
    ip   = win[47:24];
    half = win[23];
    rest = |win[22:0];
    // Magnitudes below 0.5 keep no integer bits and no half bit.
    if (rsh > 8'd24) begin
      ip   = '0;
      half = 1'b0;
      rest = 1'b1;
    end

    case (mode)
      2'b00:   inc = sgn & (half | rest);
      2'b01:   inc = ~sgn & (half | rest);
      2'b10:   inc = 1'b0;
      default: inc = half & (rest | ip[0]);
    endcase
    rmag = ip + 24'(inc);

    msb = '0;
    for (int i = 0; i < 24; i++) begin
      if (rmag[i]) msb = 5'(i);
    end
    norm = rmag[22:0] << (5'd23 - msb);

    if (expo == 8'd0)
      mag32 = '0;
    else if (expo < 8'd150)
      mag32 = {8'd0, rmag};
    else if (lsh < 8'd32)
      mag32 = {8'd0, sig} << lsh[4:0];
    else
      mag32 = '0;
    wrap = sgn ? (~mag32 + 32'd1) : mag32;

    is_nan   = (expo == 8'hFF) && (man != 23'd0);
    // -2^31 is the only value with exponent 158 that still fits.
    in_range = (expo <= 8'd157) || ((expo == 8'd158) && sgn && (man == 23'd0));

    res_ovf = 1'b0;
    if (!to_int) begin
      if (expo >= 8'd150)
        res_y = x;
      else if ((expo == 8'd0) || (rmag == 24'd0))
        res_y = '0;
      else
        res_y = {sgn, 8'd127 + {3'd0, msb}, norm};
    end else if (is_nan) begin
      res_y   = 32'h7FFF_FFFF;
      res_ovf = 1'b1;
    end else if (!in_range) begin
      res_ovf = 1'b1;
      if (SAT_INT)
        res_y = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else
        res_y = wrap;
    end else begin
      res_y = wrap;
    end
  end

  logic                   advance;
  logic [STAGES-1:0]      vld;
  logic [STAGES-1:0][31:0] yd;
  logic [STAGES-1:0]      od;

  assign out_valid = vld[STAGES-1];
  assign y         = yd[STAGES-1];
  assign ovf       = od[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance || !rstn;

  // All stages move together; a stalled output freezes the entire pipe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld <= '0;
      yd  <= '0;
      od  <= '0;
    end else if (advance) begin
      vld[0] <= in_valid;
      yd[0]  <= res_y;
      od[0]  <= res_ovf;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        yd[i]  <= yd[i-1];
        od[i]  <= od[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      ovf_cnt <= '0;
    else if (out_valid && out_ready && ovf && (ovf_cnt != 16'hFFFF))
      ovf_cnt <= ovf_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fround_pipe.sv
// Scoreboard bench for fround_pipe: directed vectors, stall and reset
// scenarios, plus an exponent sweep checked against a real-number model.
module tb_fround_pipe;

  localparam int STAGES  = 2;
  localparam bit SAT_INT = 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [1:0]  mode = '0;
  logic        to_int = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        ovf;
  logic [15:0] ovf_cnt;

  fround_pipe #(.STAGES(STAGES), .SAT_INT(SAT_INT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .mode(mode), .to_int(to_int), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [1:0]  m;
    logic        t;
    logic [31:0] y;
    logic        o;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        dv[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every delivered result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_cnt = '0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got %h expected none", y);
      end else begin
        mon_e = sb.pop_front();
        check_output("y", y, mon_e.y);
        check_output("ovf", 32'(ovf), 32'(mon_e.ovf));
        check_output("ovf_cnt", {16'd0, ovf_cnt}, {16'd0, exp_cnt});
        if (mon_e.ovf && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] xv, input logic [1:0] m, input logic t,
                                input logic [31:0] ey, input logic eo, input bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    x        = xv;
    mode     = m;
    to_int   = t;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
    end else if (push) begin
      sb.push_back('{y: ey, ovf: eo});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic real rnd(input real v, input logic [1:0] m);
    real fl;
    real d;
    fl = $floor(v);
    case (m)
      2'b00: return fl;
      2'b01: return $ceil(v);
      2'b10: return (v < 0.0) ? $ceil(v) : fl;
      default: begin
        d = v - fl;
        if (d > 0.5) return fl + 1.0;
        if (d < 0.5) return fl;
        return ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
      end
    endcase
  endfunction

  task automatic model(input logic [31:0] xv, input logic [1:0] m, input logic t,
                       output logic [31:0] ry, output logic ro);
    int          e;
    int          sigi;
    real         v;
    real         r;
    logic [63:0] b;
    longint      mag;
    logic [31:0] lo;
    e    = int'(xv[30:23]);
    sigi = 32'h0080_0000 + int'(xv[22:0]);
    v    = real'(sigi) * (2.0 ** (e - 150));
    if (xv[31]) v = -v;
    ro = 1'b0;
    ry = '0;
    if (!t) begin
      if (e >= 150) ry = xv;
      else if (e != 0) begin
        r = rnd(v, m);
        if (r != 0.0) begin
          b  = $realtobits(r);
          ry = {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
        end
      end
    end else if (e == 255 && xv[22:0] != 23'd0) begin
      ry = 32'h7FFF_FFFF;
      ro = 1'b1;
    end else if (e != 0) begin
      if (e == 255) r = xv[31] ? -1.0e300 : 1.0e300;
      else if (e < 150) r = rnd(v, m);
      else r = v;
      if (r >= -2147483648.0 && r <= 2147483647.0) begin
        ry = $rtoi(r);
      end else begin
        ro = 1'b1;
        if (SAT_INT) ry = xv[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else begin
          if (e >= 182) lo = '0;
          else begin
            mag = longint'(sigi) << (e - 150);
            lo  = mag[31:0];
          end
          ry = xv[31] ? -lo : lo;
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] snap_y;
    logic [31:0] my;
    logic        mo;
    logic [22:0] mant;
    int          n;

    dv.push_back('{32'h4F00_0000, 2'd2, 1'b1, 32'h7FFF_FFFF, 1'b1});
    dv.push_back('{32'hCF00_0000, 2'd2, 1'b1, 32'h8000_0000, 1'b0});
    dv.push_back('{32'hC020_0000, 2'd3, 1'b0, 32'hC000_0000, 1'b0});
    dv.push_back('{32'hBE99_999A, 2'd1, 1'b0, 32'h0000_0000, 1'b0});
    dv.push_back('{32'h3FA0_0000, 2'd1, 1'b0, 32'h4000_0000, 1'b0});
    dv.push_back('{32'hC070_0000, 2'd2, 1'b1, 32'hFFFF_FFFD, 1'b0});
    dv.push_back('{32'hC070_0000, 2'd0, 1'b1, 32'hFFFF_FFFC, 1'b0});
    dv.push_back('{32'h4B00_0001, 2'd3, 1'b0, 32'h4B00_0001, 1'b0});
    dv.push_back('{32'h8000_0001, 2'd0, 1'b0, 32'h0000_0000, 1'b0});
    dv.push_back('{32'h7FC0_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 1'b1});
    dv.push_back('{32'hFF80_0000, 2'd1, 1'b1, 32'h8000_0000, 1'b1});
    dv.push_back('{32'h3F00_0000, 2'd3, 1'b0, 32'h0000_0000, 1'b0});
    dv.push_back('{32'h3FC0_0000, 2'd3, 1'b0, 32'h4000_0000, 1'b0});
    dv.push_back('{32'h4F80_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 1'b1});
    dv.push_back('{32'h3DCC_CCCD, 2'd1, 1'b1, 32'h0000_0001, 1'b0});
    dv.push_back('{32'hC060_0000, 2'd3, 1'b1, 32'hFFFF_FFFC, 1'b0});
    dv.push_back('{32'h7F80_0000, 2'd2, 1'b0, 32'h7F80_0000, 1'b0});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_y", y, 32'd0);
    check_output("rst_ovf", 32'(ovf), 32'd0);
    check_output("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Latency: -1.5 floor as float, accepted on the first edge out of reset.
    apply_stimulus(32'hBFC0_0000, 2'd0, 1'b0, 32'hC000_0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      check_output("latency_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check_output("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Ties to even, back-to-back.
    apply_stimulus(32'h4020_0000, 2'd3, 1'b1, 32'd2, 1'b0, 1'b1);
    apply_stimulus(32'h4060_0000, 2'd3, 1'b1, 32'd4, 1'b0, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("b2b_first", y, 32'd2);
    @(posedge clk);
    #1;
    check_output("b2b_second_valid", 32'(out_valid), 32'd1);
    check_output("b2b_second", y, 32'd4);
    drain();

    foreach (dv[i]) apply_stimulus(dv[i].x, dv[i].m, dv[i].t, dv[i].y, dv[i].o, 1'b1);
    drain();

    // Eight-operand stream with a three-cycle output stall in the middle.
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          logic [31:0] fx;
          fx = {1'b0, 8'(127 + $clog2(k + 1) - 1), 23'd0};
          case (k)
            3: fx = 32'h4040_0000;
            5: fx = 32'h40A0_0000;
            6: fx = 32'h40C0_0000;
            7: fx = 32'h40E0_0000;
            default: ;
          endcase
          apply_stimulus(fx, 2'd2, 1'b1, 32'(k), 1'b0, 1'b1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap_y = y;
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          check_output("stall_hold_y", y, snap_y);
          check_output("stall_hold_valid", 32'(out_valid), 32'd1);
          check_output("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight: neither may ever appear.
    out_ready = 1'b0;
    apply_stimulus(32'h4F00_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    apply_stimulus(32'h4F80_0000, 2'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("inflight_rst_valid", 32'(out_valid), 32'd0);
    check_output("inflight_rst_cnt", {16'd0, ovf_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_output("inflight_gone", 32'(out_valid), 32'd0);
    end
    check_output("inflight_cnt", {16'd0, ovf_cnt}, 32'd0);
    @(posedge clk);
    #1;

    // Exponent sweep against the model.
    for (int e = 0; e < 256; e++) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 4; k++) begin
          case (k)
            0: mant = 23'd0;
            1: mant = 23'd1;
            2: mant = 23'h7F_FFFF;
            default: mant = 23'($urandom);
          endcase
          for (int md = 0; md < 4; md++) begin
            for (int t = 0; t < 2; t++) begin
              model({s[0], e[7:0], mant}, md[1:0], t[0], my, mo);
              apply_stimulus({s[0], e[7:0], mant}, md[1:0], t[0], my, mo, 1'b1);
            end
          end
        end
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
